// File: rtl/split_branch_arbiter.sv
// NUM_REQ-way arbiter feeding a two-stage conditional scale/increment pipeline (x=a*3|a, y=b+1|b).
// Define SPLIT_BRANCH_ARB_RR_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module split_branch_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                     clk_j,
    input  logic                     rst_n_j,
    input  logic [NUM_REQ-1:0]       req_valid_j,
    output logic [NUM_REQ-1:0]       req_ready_j,
    input  logic [NUM_REQ-1:0]       req_cond_j,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_j,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_j,
    output logic                     out_valid_j,
    input  logic                     out_ready_j,
    output logic [WIDTH-1:0]         out_x_j,
    output logic [WIDTH-1:0]         out_y_j,
    output logic [1:0]               out_id_j,
    output logic                     busy_j
);

    typedef enum logic {StEmpty, StFull} stage_e;

    stage_e             s1_state_q, s2_state_q;
    logic [WIDTH-1:0]   s1_a_q, s1_b_q;
    logic               s1_cond_q;
    logic [1:0]         s1_id_q;
    logic [WIDTH-1:0]   s2_x_q, s2_y_q;
    logic [1:0]         s2_id_q;
    logic [WIDTH-1:0]   s2_x_d, s2_y_d;

    logic [1:0]         winner;
    logic               any_valid;
    logic               s1_full, s2_full;
    logic               s2_load, s1_accept;
    logic [WIDTH-1:0]   a_sel, b_sel;
    logic               cond_sel;

    assign any_valid = |req_valid_j;
    assign s1_full   = (s1_state_q == StFull);
    assign s2_full   = (s2_state_q == StFull);
    assign s2_load   = s1_full && (!s2_full || out_ready_j);
    // Ready is forced low while reset is asserted even though both stages are already empty.
    assign s1_accept = rst_n_j && any_valid && (!s1_full || s2_load);

`ifdef SPLIT_BRANCH_ARB_RR_EN
    logic [1:0] ptr_q;

    // Pick the valid requester at the smallest circular distance after the last grant.
    always_comb begin
        int unsigned best;
        int unsigned dist;
        winner = '0;
        best   = NUM_REQ;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            dist = (int'(i) + NUM_REQ - 1 - 32'(ptr_q)) % NUM_REQ;
            if (req_valid_j[i] && (dist < best)) begin
                best   = dist;
                winner = 2'(i);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid_j[i]) begin
                winner = 2'(i);
            end
        end
    end
`endif

    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        cond_sel = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == 2'(i)) begin
                a_sel    = req_a_j[i*WIDTH +: WIDTH];
                b_sel    = req_b_j[i*WIDTH +: WIDTH];
                cond_sel = req_cond_j[i];
            end
        end
    end

    always_comb begin
        req_ready_j = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_ready_j[i] = s1_accept && (winner == 2'(i));
        end
    end

    // a*3 as a + (a << 1); both results wrap at WIDTH bits.
    always_comb begin
        if (s1_cond_q) begin
            s2_x_d = s1_a_q + {s1_a_q[WIDTH-2:0], 1'b0};
            s2_y_d = s1_b_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            s2_x_d = s1_a_q;
            s2_y_d = s1_b_q;
        end
    end

    always_ff @(posedge clk_j or negedge rst_n_j) begin
        if (!rst_n_j) begin
            s1_state_q <= StEmpty;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cond_q  <= 1'b0;
            s1_id_q    <= '0;
            s2_state_q <= StEmpty;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            s2_id_q    <= '0;
`ifdef SPLIT_BRANCH_ARB_RR_EN
            ptr_q      <= 2'(NUM_REQ - 1);
`endif
        end else begin
            if (s1_accept) begin
                s1_state_q <= StFull;
                s1_a_q     <= a_sel;
                s1_b_q     <= b_sel;
                s1_cond_q  <= cond_sel;
                s1_id_q    <= winner;
`ifdef SPLIT_BRANCH_ARB_RR_EN
                ptr_q      <= winner;
`endif
            end else if (s2_load) begin
                s1_state_q <= StEmpty;
            end

            if (s2_load) begin
                s2_state_q <= StFull;
                s2_x_q     <= s2_x_d;
                s2_y_q     <= s2_y_d;
                s2_id_q    <= s1_id_q;
            end else if (s2_full && out_ready_j) begin
                s2_state_q <= StEmpty;
            end
        end
    end

    assign out_valid_j = s2_full;
    assign out_x_j     = s2_x_q;
    assign out_y_j     = s2_y_q;
    assign out_id_j    = s2_id_q;
    assign busy_j      = s1_full || s2_full;

endmodule

// File: tb/tb_split_branch_arbiter.sv
// Directed and randomised check of split_branch_arbiter against a queue-based reference model.
// Follows SPLIT_BRANCH_ARB_RR_EN the same way the design does.
module tb_split_branch_arbiter;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 8;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [1:0]       id;
    } res_t;

    logic                     clk_j = 1'b0;
    logic                     rst_n_j;
    logic [NUM_REQ-1:0]       req_valid_j;
    logic [NUM_REQ-1:0]       req_ready_j;
    logic [NUM_REQ-1:0]       req_cond_j;
    logic [NUM_REQ*WIDTH-1:0] req_a_j;
    logic [NUM_REQ*WIDTH-1:0] req_b_j;
    logic                     out_valid_j;
    logic                     out_ready_j;
    logic [WIDTH-1:0]         out_x_j;
    logic [WIDTH-1:0]         out_y_j;
    logic [1:0]               out_id_j;
    logic                     busy_j;

    split_branch_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk_j       (clk_j),
        .rst_n_j     (rst_n_j),
        .req_valid_j (req_valid_j),
        .req_ready_j (req_ready_j),
        .req_cond_j  (req_cond_j),
        .req_a_j     (req_a_j),
        .req_b_j     (req_b_j),
        .out_valid_j (out_valid_j),
        .out_ready_j (out_ready_j),
        .out_x_j     (out_x_j),
        .out_y_j     (out_y_j),
        .out_id_j    (out_id_j),
        .busy_j      (busy_j)
    );

    always #5 clk_j = ~clk_j;

    // Reference model: pend = accepted but not yet presented, vis = presented at the output.
    res_t               pend[$];
    res_t               vis[$];
    int                 last_gnt;
    bit                 accepted[NUM_REQ];
    logic [NUM_REQ-1:0] rdy_seen;
    int                 n_checks;
    int                 n_errs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t model_result(input int i);
        int   av;
        int   bv;
        res_t r;
        av = int'(req_a_j[i*WIDTH +: WIDTH]);
        bv = int'(req_b_j[i*WIDTH +: WIDTH]);
        if (req_cond_j[i]) begin
            av = (av * 3) % (1 << WIDTH);
            bv = (bv + 1) % (1 << WIDTH);
        end
        r.x  = WIDTH'(av);
        r.y  = WIDTH'(bv);
        r.id = 2'(i);
        return r;
    endfunction

    function automatic int exp_winner();
`ifdef SPLIT_BRANCH_ARB_RR_EN
        for (int k = 1; k <= NUM_REQ; k++) begin
            int i;
            i = (last_gnt + k) % NUM_REQ;
            if (req_valid_j[i]) return i;
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_j[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c);
        req_valid_j[i]             = 1'b1;
        req_a_j[i*WIDTH +: WIDTH]  = a;
        req_b_j[i*WIDTH +: WIDTH]  = b;
        req_cond_j[i]              = c;
    endtask

    task automatic renew(input bit keep);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accepted[i]) begin
                if (keep) set_req(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                else req_valid_j[i] = 1'b0;
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int                 w;
        bit                 can_move;
        bit                 can_acc;
        logic [NUM_REQ-1:0] exp_rdy;
        for (int i = 0; i < NUM_REQ; i++) accepted[i] = 1'b0;
        #1;
        can_move = (pend.size() > 0) && ((vis.size() == 0) || out_ready_j);
        can_acc  = (pend.size() == 0) || can_move;
        w        = exp_winner();
        exp_rdy  = '0;
        if (w >= 0 && can_acc) exp_rdy[w] = 1'b1;
        rdy_seen = req_ready_j;
        check_eq("req_ready", 32'(req_ready_j), 32'(exp_rdy));
        check_eq("out_valid", 32'(out_valid_j), 32'(vis.size() > 0));
        check_eq("busy", 32'(busy_j), 32'((pend.size() + vis.size()) > 0));
        if (vis.size() > 0) begin
            check_eq("out_result", 32'({out_x_j, out_y_j, out_id_j}), 32'(vis[0]));
        end
        @(posedge clk_j);
        if ((vis.size() > 0) && out_ready_j) void'(vis.pop_front());
        if (can_move) vis.push_back(pend.pop_front());
        if (exp_rdy != '0) begin
            pend.push_back(model_result(w));
            last_gnt    = w;
            accepted[w] = 1'b1;
        end
        @(negedge clk_j);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_g;
        n_checks    = 0;
        n_errs      = 0;
        rst_n_j     = 1'b0;
        req_valid_j = '1;
        req_cond_j  = '0;
        req_a_j     = '0;
        req_b_j     = '0;
        out_ready_j = 1'b1;
        last_gnt    = NUM_REQ - 1;

        // Reset values, with requests pending so ready must still be held low.
        @(negedge clk_j);
        #1;
        check_eq("rst_out_valid", 32'(out_valid_j), 32'h0);
        check_eq("rst_busy", 32'(busy_j), 32'h0);
        check_eq("rst_x", 32'(out_x_j), 32'h0);
        check_eq("rst_y", 32'(out_y_j), 32'h0);
        check_eq("rst_id", 32'(out_id_j), 32'h0);
        check_eq("rst_ready", 32'(req_ready_j), 32'h0);
        req_valid_j = '0;
        @(negedge clk_j);
        rst_n_j = 1'b1;

        // Single request, two-cycle latency.
        set_req(0, 8'h05, 8'h10, 1'b1);
        step();
        req_valid_j[0] = 1'b0;
        step();
        check_eq("single_valid", 32'(out_valid_j), 32'h1);
        check_eq("single_x", 32'(out_x_j), 32'h0F);
        check_eq("single_y", 32'(out_y_j), 32'h11);
        check_eq("single_id", 32'(out_id_j), 32'h0);
        step();

        // Wrap-around arithmetic, both branch outcomes.
        set_req(1, 8'hFF, 8'hFF, 1'b1);
        step();
        req_valid_j[1] = 1'b0;
        step();
        check_eq("wrap_x", 32'(out_x_j), 32'hFD);
        check_eq("wrap_y", 32'(out_y_j), 32'h00);
        check_eq("wrap_id", 32'(out_id_j), 32'h1);
        step();
        set_req(1, 8'hFF, 8'hFF, 1'b0);
        step();
        req_valid_j[1] = 1'b0;
        step();
        check_eq("pass_x", 32'(out_x_j), 32'hFF);
        check_eq("pass_y", 32'(out_y_j), 32'hFF);
        step();

        // Contention between requesters 0 and 1 at full throughput.
        out_ready_j = 1'b1;
        set_req(0, 8'($urandom), 8'($urandom), 1'b1);
        set_req(1, 8'($urandom), 8'($urandom), 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
`ifdef SPLIT_BRANCH_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 1 : 2;
`else
            exp_g = 1;
`endif
            check_eq("contend_gnt", 32'(rdy_seen), 32'(exp_g));
            renew(1'b1);
        end
        req_valid_j = '0;
        repeat (3) step();

        // Backpressure: fill both stages, stall five cycles, then release.
        out_ready_j = 1'b0;
        set_req(0, 8'($urandom), 8'($urandom), 1'b1);
        set_req(1, 8'($urandom), 8'($urandom), 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            renew(1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_ready", 32'(rdy_seen), 32'h0);
        end
        out_ready_j = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            renew(1'b0);
        end

        // Reset with both stages full.
        out_ready_j = 1'b0;
        set_req(0, 8'($urandom), 8'($urandom), 1'b1);
        set_req(1, 8'($urandom), 8'($urandom), 1'b1);
        for (int k = 0; k < 2; k++) begin
            step();
            renew(1'b1);
        end
        check_eq("pre_rst_busy", 32'(busy_j), 32'h1);
        rst_n_j = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid_j), 32'h0);
        check_eq("mid_rst_busy", 32'(busy_j), 32'h0);
        check_eq("mid_rst_ready", 32'(req_ready_j), 32'h0);
        pend.delete();
        vis.delete();
        last_gnt = NUM_REQ - 1;
        repeat (2) @(negedge clk_j);
        rst_n_j     = 1'b1;
        out_ready_j = 1'b1;
        step();
        check_eq("post_rst_gnt", 32'(rdy_seen), 32'h1);

        // Random traffic with random backpressure.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_j[i] && accepted[i]) req_valid_j[i] = 1'b0;
                if (!req_valid_j[i] && ($urandom_range(0, 99) < 55)) begin
                    set_req(i, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
            end
            out_ready_j = ($urandom_range(0, 99) < 65);
            step();
        end
        renew(1'b0);
        req_valid_j = '0;
        out_ready_j = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
